// File: rtl/alu_pkg.sv
// alu_pkg -- types shared by the multicycle ALU and its iterative engine.
//   alu_op_t    : encodings of the 4-bit alucont operation code
//   alu_state_t : control FSM states (IDLE, ITER, DONE)
//   MODE_MUL/DIV: engine mode select values
package alu_pkg;

  typedef enum logic [3:0] {
    OP_AND  = 4'b0000,
    OP_OR   = 4'b0001,
    OP_ADD  = 4'b0010,
    OP_SLL  = 4'b0011,
    OP_SRL  = 4'b0100,
    OP_XOR  = 4'b0101,
    OP_SUB  = 4'b0110,
    OP_SLTU = 4'b0111,
    OP_MULU = 4'b1000,
    OP_DIVU = 4'b1001,
    OP_SRA  = 4'b1010,
    OP_SLT  = 4'b1011
  } alu_op_t;

  typedef enum logic [1:0] {
    S_IDLE,
    S_ITER,
    S_DONE
  } alu_state_t;

  localparam logic MODE_MUL = 1'b0;
  localparam logic MODE_DIV = 1'b1;

endpackage

// File: rtl/iter_muldiv.sv
// iter_muldiv -- WIDTH-step unsigned shift-add multiplier / restoring divider.
// Ports:
//   clk, reset : clock, asynchronous active-high reset
//   start      : latch a, b, mode and begin a WIDTH-step run
//   mode       : MODE_MUL or MODE_DIV
//   a, b       : multiplicand/multiplier or dividend/divisor
//   hi, lo     : value the accumulator pair takes after the current step;
//                on the done cycle this is {product} or {remainder, quotient}
//   done       : high during the cycle that performs the final step
module iter_muldiv #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic             mode,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic [WIDTH-1:0] hi,
  output logic [WIDTH-1:0] lo,
  output logic             done
);
  import alu_pkg::*;

  localparam int CW = $clog2(WIDTH);

  logic             running;
  logic             mode_q;
  logic [CW-1:0]    cnt;
  logic [WIDTH-1:0] acc;
  logic [WIDTH-1:0] shreg;
  logic [WIDTH-1:0] opnd;
  logic [WIDTH:0]   mul_sum;
  logic [WIDTH:0]   div_shifted;
  logic [WIDTH:0]   div_diff;

  // One step of either algorithm. Multiply: conditionally add the
  // multiplicand into the upper half, then shift the {acc, shreg} pair right.
  // Divide: shift the next dividend bit into the partial remainder and keep
  // the subtraction only if it does not go negative.
  always_comb begin
    mul_sum     = {1'b0, acc} + (shreg[0] ? {1'b0, opnd} : '0);
    div_shifted = {acc, shreg[WIDTH-1]};
    div_diff    = div_shifted - {1'b0, opnd};
    hi          = mul_sum[WIDTH:1];
    lo          = {mul_sum[0], shreg[WIDTH-1:1]};
    if (mode_q == MODE_DIV) begin
      if (div_shifted >= {1'b0, opnd}) begin
        hi = div_diff[WIDTH-1:0];
        lo = {shreg[WIDTH-2:0], 1'b1};
      end else begin
        hi = div_shifted[WIDTH-1:0];
        lo = {shreg[WIDTH-2:0], 1'b0};
      end
    end
  end

  assign done = running && (cnt == CW'(WIDTH - 1));

  // Operand latch and step counter; the run stops itself after WIDTH steps.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      running <= 1'b0;
      mode_q  <= MODE_MUL;
      cnt     <= '0;
      acc     <= '0;
      shreg   <= '0;
      opnd    <= '0;
    end else if (start) begin
      running <= 1'b1;
      mode_q  <= mode;
      cnt     <= '0;
      acc     <= '0;
      shreg   <= a;
      opnd    <= b;
    end else if (running) begin
      acc   <= hi;
      shreg <= lo;
      cnt   <= cnt + 1'b1;
      if (done) begin
        running <= 1'b0;
      end
    end
  end

endmodule

// File: rtl/multicycle_alu.sv
// multicycle_alu -- ALU with single-cycle logic/arith ops and iterative
// unsigned multiply/divide.
// Ports:
//   clk, reset     : clock, asynchronous active-high reset
//   start, alucont : request and opcode, sampled together with a, b
//   a, b           : WIDTH-bit operands
//   busy           : iterative op in progress (start ignored)
//   done           : one-cycle pulse when result/hi/zero/err are new
//   result, hi     : primary result, and product high half / remainder
//   zero, err      : result==0, illegal opcode or divide by zero
module multicycle_alu #(
  parameter int WIDTH = 32,
  parameter int SHW   = $clog2(WIDTH)
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic [3:0]       alucont,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] result,
  output logic [WIDTH-1:0] hi,
  output logic             zero,
  output logic             err
);
  import alu_pkg::*;

  alu_state_t       state, state_d;
  logic             accept;
  logic             load_sc, load_eng;
  logic             eng_start, eng_mode, eng_done;
  logic [WIDTH-1:0] eng_hi, eng_lo;
  logic [WIDTH-1:0] sc_result, sc_hi;
  logic             sc_err, sc_iter;
  logic [SHW-1:0]   shamt;

  assign shamt = b[SHW-1:0];

  // Single-cycle datapath. MULU and nonzero-divisor DIVU only raise sc_iter;
  // their results come from the iterative engine instead.
  always_comb begin
    sc_result = '0;
    sc_hi     = '0;
    sc_err    = 1'b0;
    sc_iter   = 1'b0;
    case (alucont)
      OP_AND:  sc_result = a & b;
      OP_OR:   sc_result = a | b;
      OP_ADD:  sc_result = a + b;
      OP_SLL:  sc_result = a << shamt;
      OP_SRL:  sc_result = a >> shamt;
      OP_XOR:  sc_result = a ^ b;
      OP_SUB:  sc_result = a - b;
      OP_SLTU: sc_result = {{(WIDTH-1){1'b0}}, (a < b)};
      OP_MULU: sc_iter = 1'b1;
      OP_DIVU: begin
        if (b == '0) begin
          sc_result = '1;
          sc_hi     = a;
          sc_err    = 1'b1;
        end else begin
          sc_iter = 1'b1;
        end
      end
      OP_SRA:  sc_result = $unsigned($signed(a) >>> shamt);
      OP_SLT:  sc_result = {{(WIDTH-1){1'b0}}, ($signed(a) < $signed(b))};
      default: sc_err = 1'b1;
    endcase
  end

  assign accept    = start && (state != S_ITER);
  assign eng_start = accept && sc_iter;
  assign eng_mode  = (alucont == OP_DIVU) ? MODE_DIV : MODE_MUL;

  iter_muldiv #(.WIDTH(WIDTH)) u_engine (
    .clk   (clk),
    .reset (reset),
    .start (eng_start),
    .mode  (eng_mode),
    .a     (a),
    .b     (b),
    .hi    (eng_hi),
    .lo    (eng_lo),
    .done  (eng_done)
  );

  // Control FSM: DONE behaves like IDLE for accepting a new request, which
  // gives back-to-back operation without an idle bubble.
  always_comb begin
    state_d  = state;
    load_sc  = 1'b0;
    load_eng = 1'b0;
    case (state)
      S_IDLE, S_DONE: begin
        if (accept) begin
          if (sc_iter) begin
            state_d = S_ITER;
          end else begin
            state_d = S_DONE;
            load_sc = 1'b1;
          end
        end else begin
          state_d = S_IDLE;
        end
      end
      S_ITER: begin
        if (eng_done) begin
          state_d  = S_DONE;
          load_eng = 1'b1;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state <= S_IDLE;
    end else begin
      state <= state_d;
    end
  end

  // Output registers only change on DONE entry, so they hold until the next
  // accepted operation completes regardless of operand activity.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      result <= '0;
      hi     <= '0;
      zero   <= 1'b1;
      err    <= 1'b0;
    end else if (load_sc) begin
      result <= sc_result;
      hi     <= sc_hi;
      zero   <= (sc_result == '0);
      err    <= sc_err;
    end else if (load_eng) begin
      result <= eng_lo;
      hi     <= eng_hi;
      zero   <= (eng_lo == '0);
      err    <= 1'b0;
    end
  end

  assign busy = (state == S_ITER);
  assign done = (state == S_DONE);

endmodule
